// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers.
// A grant lasts up to MAX_BURST beats and is followed by one idle arbitration cycle.
//
// state    | meaning
// ST_IDLE  | no grant; pick next valid requester after last_q
// ST_GRANT | requester grant_id_q owns the fifo write port
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BW   = 4,
   parameter int MAX_BURST = 4,
   localparam int IDW      = $clog2(NUM_REQ),
   localparam int CW       = $clog2(MAX_BURST + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*DATA_BW-1:0] req_data_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic                       fifo_full_i,
   output logic                       fifo_wen_o,
   output logic [DATA_BW-1:0]         fifo_wdata_o,
   output logic [IDW-1:0]             grant_id_o,
   output logic                       busy_o
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   logic           state_q, state_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic [IDW-1:0] last_q, last_d;
   logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
   logic [IDW-1:0] pick;
   logic [IDW-1:0] sel;

   // Scan downward so the last hit is the nearest index after last_q.
   always_comb begin
      pick = last_q;
      sel  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         sel = IDW'((int'(last_q) + i) % NUM_REQ);
         if (req_valid_i[sel]) pick = sel;
      end
   end

   always_comb begin
      req_ready_o  = '0;
      fifo_wen_o   = 1'b0;
      fifo_wdata_o = '0;
      if (state_q == ST_GRANT) begin
         req_ready_o[grant_id_q] = !fifo_full_i;
         fifo_wen_o              = req_valid_i[grant_id_q] && !fifo_full_i;
         fifo_wdata_o            = req_data_i[int'(grant_id_q)*DATA_BW +: DATA_BW];
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) begin
               state_d    = ST_GRANT;
               grant_id_d = pick;
               last_d     = pick;
               beat_cnt_d = '0;
            end
         end
         default: begin
            if (!req_valid_i[grant_id_q]) begin
               state_d = ST_IDLE;
            end else if (fifo_wen_o) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == CW'(MAX_BURST - 1)) state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         grant_id_q <= '0;
         last_q     <= IDW'(NUM_REQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign grant_id_o = grant_id_q;
   assign busy_o     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle pattern checks plus a
// scoreboard of expected {grant_id, wdata} for every fifo write.
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wen;
   logic [3:0]  fifo_wdata;
   logic [1:0]  grant_id;
   logic        busy;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_BW(4), .MAX_BURST(4)) dut (
      .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_data_i(req_data),
      .req_ready_o(req_ready), .fifo_full_i(fifo_full), .fifo_wen_o(fifo_wen),
      .fifo_wdata_o(fifo_wdata), .grant_id_o(grant_id), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [5:0]  exp_q[$];
   logic [63:0] wen_v, busy_v, rdy_v;
   logic [1:0]  gid_v [64];
   int          cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr();
      cyc = 0;
      wen_v = '0;
      busy_v = '0;
      rdy_v = '0;
   endtask

   // Sample one cycle at a time, 1 time unit after the falling edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         wen_v[cyc]  = fifo_wen;
         busy_v[cyc] = busy;
         rdy_v[cyc]  = |req_ready;
         gid_v[cyc]  = grant_id;
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic push(input int id, input int n);
      logic [1:0] i2;
      logic [3:0] d;
      i2 = 2'(id);
      d  = 4'hA + 4'(id);
      for (int k = 0; k < n; k++) exp_q.push_back({i2, d});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      #1;
      check("reset_outputs", {busy, fifo_wen, req_ready, grant_id, fifo_wdata}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      clr();
   endtask

   // Monitor: a beat is written on the rising edge; sample just before it.
   initial begin
      logic [5:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (fifo_wen) begin
            check("wen_while_full", fifo_full, 1'b0);
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected_write: got id=%0d data=%0h expected no write", grant_id, fifo_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({grant_id, fifo_wdata} !== e) begin
                  n_err++;
                  $display("FAIL sb_write: got id=%0d data=%0h expected id=%0d data=%0h",
                           grant_id, fifo_wdata, e[5:4], e[3:0]);
               end
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] e25;
      reset = 1'b1;
      req_valid = '0;
      req_data = 16'hDCBA;
      fifo_full = 1'b0;
      clr();

      // 1: single requester, two back-to-back bursts
      do_reset();
      push(0, 8);
      req_valid = 4'b0001;
      run(10);
      req_valid = '0;
      check("t1_wen", wen_v[9:0], 10'b1111011110);
      check("t1_busy", busy_v[9:0], 10'b1111011110);
      check("t1_ready", rdy_v[9:0], 10'b1111011110);
      check("t1_gid", gid_v[1], 2'd0);

      // 2: all requesting, full rotation
      do_reset();
      push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
      req_valid = 4'b1111;
      run(25);
      req_valid = '0;
      e25 = '0;
      for (int k = 0; k < 25; k++) e25[k] = (k % 5) != 0;
      check("t2_wen", wen_v[24:0], e25[24:0]);
      check("t2_busy", busy_v[24:0], e25[24:0]);
      check("t2_writes20", 64'($countones(wen_v[19:0])), 64'd16);
      for (int g = 0; g < 5; g++) check("t2_gid", gid_v[1 + 5*g], 64'(g % 4));

      // 3: fifo full stall after beat 2
      do_reset();
      push(0, 4);
      req_valid = 4'b0001;
      run(3);
      fifo_full = 1'b1;
      run(3);
      fifo_full = 1'b0;
      run(2);
      req_valid = '0;
      run(1);
      check("t3_wen", wen_v[8:0], 9'b011000110);
      check("t3_busy", busy_v[8:0], 9'b011111110);
      check("t3_ready", rdy_v[8:0], 9'b011000110);
      check("t3_writes", 64'($countones(wen_v[8:0])), 64'd4);

      // 4: requester 1 drops valid after 2 beats
      do_reset();
      push(1, 2); push(2, 4);
      req_valid = 4'b0110;
      run(3);
      req_valid = 4'b0100;
      run(6);
      req_valid = '0;
      run(1);
      check("t4_wen", wen_v[9:0], 10'b0111100110);
      check("t4_busy", busy_v[9:0], 10'b0111101110);
      check("t4_ready", rdy_v[9:0], 10'b0111101110);
      check("t4_gid1", gid_v[1], 2'd1);
      check("t4_gid2", gid_v[5], 2'd2);

      // 5: async reset mid-beat of requester 2
      do_reset();
      push(2, 1);
      req_valid = 4'b0100;
      run(2);
      #1;
      check("t5_pre_wen", {busy, fifo_wen}, 2'b11);
      #1;
      reset = 1'b1;
      #1;
      check("t5_async", {busy, fifo_wen, req_ready}, 6'd0);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      clr();
      push(0, 4);
      req_valid = 4'b1111;
      run(5);
      req_valid = '0;
      check("t5_gid", gid_v[1], 2'd0);
      check("t5_wen", wen_v[4:0], 5'b11110);

      // 6: wrap-around of last pointer
      do_reset();
      push(3, 4); push(0, 4);
      req_valid = 4'b1000;
      run(5);
      req_valid = 4'b1111;
      run(5);
      req_valid = '0;
      check("t6_gid3", gid_v[1], 2'd3);
      check("t6_gid0", gid_v[6], 2'd0);
      check("t6_wen", wen_v[9:0], 10'b1111011110);

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
